// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and key-position lookup for the keypad matrix
// emulator, the scanner and the benches.
// Build option: KEYPAD_BOUNCE_EN adds the press/release bounce states.
package keypad_pkg;

`ifdef KEYPAD_BOUNCE_EN
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HOLD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } kp_state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd2
    } kp_state_e;
`endif

    // Matrix position of a key: row driven by the scanner, column sensed.
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } kp_pos_t;

    // Hex key to {row, col}. Layout, columns left to right:
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
    function automatic kp_pos_t key_to_pos(input logic [3:0] code);
        kp_pos_t p;
        case (code)
            4'h1:    p = {2'd0, 2'd0};
            4'h2:    p = {2'd0, 2'd1};
            4'h3:    p = {2'd0, 2'd2};
            4'hA:    p = {2'd0, 2'd3};
            4'h4:    p = {2'd1, 2'd0};
            4'h5:    p = {2'd1, 2'd1};
            4'h6:    p = {2'd1, 2'd2};
            4'hB:    p = {2'd1, 2'd3};
            4'h7:    p = {2'd2, 2'd0};
            4'h8:    p = {2'd2, 2'd1};
            4'h9:    p = {2'd2, 2'd2};
            4'hC:    p = {2'd2, 2'd3};
            4'hE:    p = {2'd3, 2'd0};
            4'h0:    p = {2'd3, 2'd1};
            4'hF:    p = {2'd3, 2'd2};
            4'hD:    p = {2'd3, 2'd3};
            default: p = {2'd3, 2'd1};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_phase_timer.sv
// keypad_phase_timer: down-counter timing one bounce phase or the hold.
// start_i loads load_i; expire_o is high in the last cycle of the interval,
// so a load of N gives exactly N cycles. The counter parks at zero.
module keypad_phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          start_i,
    input  logic [CW-1:0] load_i,
    output logic          expire_o
);

    logic [CW-1:0] cnt_q;

    // Countdown register: reload has priority, otherwise decrement and stop at zero.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt_q <= {CW{1'b0}};
        end else if (start_i) begin
            cnt_q <= load_i;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: emulates one key of a 4x4 active-low matrix keypad
// being pressed, held and released, optionally with contact bounce.
// Build option: KEYPAD_BOUNCE_EN enables the press/release bounce bursts;
// without it a press is a clean HOLD_CYCLES closure.
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 100000,
    parameter int BOUNCE_CYCLES = 10000,
    parameter int BOUNCE_COUNT  = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       press_req,
    input  logic [3:0] key_code,
    input  logic [3:0] key_rows,
    output logic [3:0] key_cols,
    output logic       busy,
    output logic       done
);

    import keypad_pkg::*;

`ifdef KEYPAD_BOUNCE_EN
    localparam int MAX_CYC = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
`else
    localparam int MAX_CYC = HOLD_CYCLES;
`endif
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

`ifdef KEYPAD_BOUNCE_EN
    localparam int PW = $clog2(2 * BOUNCE_COUNT);
    localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_CYCLES);
    localparam logic [PW-1:0] PHASE_LAST  = PW'(2 * BOUNCE_COUNT - 1);
    localparam logic [PW-1:0] PHASE_ONE   = PW'(1);

    logic [PW-1:0] phase_q, phase_d;
`endif

    kp_state_e     state_q, state_d;
    logic [3:0]    key_q, key_d;
    logic          contact_q, contact_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tmr_start_s;
    logic [CW-1:0] tmr_load_s;
    logic          tmr_expire_s;
    kp_pos_t       pos_s;

    keypad_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .start_i  (tmr_start_s),
        .load_i   (tmr_load_s),
        .expire_o (tmr_expire_s)
    );

    // State, latched key, contact and handshake registers.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q   <= IDLE;
            key_q     <= 4'h0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            phase_q   <= {PW{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            contact_q <= contact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef KEYPAD_BOUNCE_EN
            phase_q   <= phase_d;
`endif
        end
    end

    // Next-state logic: sequences accept, bounce phases, hold and release.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        contact_d   = contact_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tmr_start_s = 1'b0;
        tmr_load_s  = {CW{1'b0}};
`ifdef KEYPAD_BOUNCE_EN
        phase_d     = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (press_req) begin
                    key_d       = key_code;
                    contact_d   = 1'b1;
                    busy_d      = 1'b1;
                    tmr_start_s = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
                    state_d     = PRESS_BOUNCE;
                    phase_d     = {PW{1'b0}};
                    tmr_load_s  = BOUNCE_LOAD;
`else
                    state_d     = HOLD;
                    tmr_load_s  = HOLD_LOAD;
`endif
                end else begin
                    contact_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            PRESS_BOUNCE: begin
                if (tmr_expire_s) begin
                    tmr_start_s = 1'b1;
                    if (phase_q == PHASE_LAST) begin
                        state_d    = HOLD;
                        contact_d  = 1'b1;
                        phase_d    = {PW{1'b0}};
                        tmr_load_s = HOLD_LOAD;
                    end else begin
                        // Even phases are closed, so the next one is closed iff this one is odd.
                        phase_d    = phase_q + PHASE_ONE;
                        contact_d  = phase_q[0];
                        tmr_load_s = BOUNCE_LOAD;
                    end
                end else begin
                    state_d = PRESS_BOUNCE;
                end
            end
`endif
            HOLD: begin
                if (tmr_expire_s) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d     = RELEASE_BOUNCE;
                    contact_d   = 1'b0;
                    phase_d     = {PW{1'b0}};
                    tmr_start_s = 1'b1;
                    tmr_load_s  = BOUNCE_LOAD;
`else
                    state_d   = IDLE;
                    contact_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
`endif
                end else begin
                    state_d = HOLD;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            RELEASE_BOUNCE: begin
                if (tmr_expire_s) begin
                    if (phase_q == PHASE_LAST) begin
                        state_d   = IDLE;
                        contact_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        phase_d   = {PW{1'b0}};
                    end else begin
                        // Even phases are open, so the next one is closed iff this one is even.
                        phase_d     = phase_q + PHASE_ONE;
                        contact_d   = ~phase_q[0];
                        tmr_start_s = 1'b1;
                        tmr_load_s  = BOUNCE_LOAD;
                    end
                end else begin
                    state_d = RELEASE_BOUNCE;
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                contact_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign pos_s = key_to_pos(key_q);

    // Column sense: pull the latched key's column low while its row is driven and contact is closed.
    always_comb begin
        key_cols = 4'b1111;
        if (contact_q && (key_rows[pos_s.row] == 1'b0)) begin
            key_cols[pos_s.col] = 1'b0;
        end else begin
            key_cols = 4'b1111;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with a per-cycle scoreboard.
// Expectations for the bounce pattern follow KEYPAD_BOUNCE_EN when defined.
module tb_keypad_matrix_emulator;

    localparam int HOLD = 20;
    localparam int BCYC = 3;
    localparam int BCNT = 2;
`ifdef KEYPAD_BOUNCE_EN
    localparam int HOLD_START = 2 * BCNT * BCYC;
`else
    localparam int HOLD_START = 0;
`endif

    logic       clk_in = 1'b0;
    logic       reset;
    logic       press_req;
    logic [3:0] key_code;
    logic [3:0] key_rows;
    logic [3:0] key_cols;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] cols;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

    keypad_matrix_emulator #(
        .HOLD_CYCLES   (HOLD),
        .BOUNCE_CYCLES (BCYC),
        .BOUNCE_COUNT  (BCNT)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .press_req (press_req),
        .key_code  (key_code),
        .key_rows  (key_rows),
        .key_cols  (key_cols),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    // Column pattern for a closed contact on key with the given row drive.
    function automatic logic [3:0] model_cols(input logic [3:0] key, input logic [3:0] rows);
        logic [3:0] m;
        int r;
        int c;
        r = 0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            if (kmap[i] == key) begin
                r = i / 4;
                c = i % 4;
            end
        end
        m = 4'b1111;
        if (rows[r] == 1'b0) m[c] = 1'b0;
        return m;
    endfunction

    function automatic void push_exp(input logic [3:0] cols, input logic b, input logic d);
        exp_t e;
        e.cols = cols;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endfunction

    // Expected trace for one full press, one entry per cycle after the accept edge.
    function automatic void push_trace(input logic [3:0] key, input logic [3:0] rows);
        logic [3:0] m;
        m = model_cols(key, rows);
`ifdef KEYPAD_BOUNCE_EN
        for (int p = 0; p < 2 * BCNT; p++)
            for (int k = 0; k < BCYC; k++)
                push_exp((p % 2 == 0) ? m : 4'b1111, 1'b1, 1'b0);
`endif
        for (int k = 0; k < HOLD; k++) push_exp(m, 1'b1, 1'b0);
`ifdef KEYPAD_BOUNCE_EN
        for (int p = 0; p < 2 * BCNT; p++)
            for (int k = 0; k < BCYC; k++)
                push_exp((p % 2 == 1) ? m : 4'b1111, 1'b1, 1'b0);
`endif
        push_exp(4'b1111, 1'b0, 1'b1);
    endfunction

    task automatic cmp(input string tag, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        assert (act === expv) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, act, expv);
    endtask

    // Advance one cycle and compare the DUT against the oldest expectation.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk_in);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, " cols"}, key_cols, e.cols);
            cmp({tag, " busy"}, {3'b000, busy}, {3'b000, e.busy});
            cmp({tag, " done"}, {3'b000, done}, {3'b000, e.done});
        end
    endtask

    task automatic idle(input int n, input string tag);
        press_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_exp(4'b1111, 1'b0, 1'b0);
            step(tag);
        end
    endtask

    // Request a press; optionally inject a second request at cycle inj_idx and stop after stop_after cycles.
    task automatic press(input logic [3:0] key, input logic [3:0] rows, input int inj_idx,
                         input logic [3:0] inj_key, input int stop_after, input string tag);
        int n;
        key_rows = rows;
        push_trace(key, rows);
        n = (stop_after < 0) ? exp_q.size() : stop_after;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                press_req = 1'b1;
                key_code  = key;
            end else if (i == inj_idx) begin
                press_req = 1'b1;
                key_code  = inj_key;
            end else begin
                press_req = 1'b0;
            end
            step(tag);
        end
        press_req = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        press_req = 1'b0;
        key_code  = 4'h0;
        key_rows  = 4'b0000;

        for (int i = 0; i < 5; i++) begin
            push_exp(4'b1111, 1'b0, 1'b0);
            step("reset");
        end
        reset = 1'b1;
        idle(2, "idle0");

        press(4'h5, 4'b1101, -1, 4'h0, -1, "key5");
        idle(2, "idle1");
        press(4'h5, 4'b0000, -1, 4'h0, -1, "multirow");
        idle(1, "idle2");
        press(4'hD, 4'b1011, -1, 4'h0, -1, "wrongrow");
        idle(1, "idle3");
        press(4'hD, 4'b0111, -1, 4'h0, -1, "keyD");
        idle(1, "idle4");
        press(4'hA, 4'b1110, -1, 4'h0, -1, "keyA");
        idle(1, "idle5");

        press(4'hA, 4'b0110, HOLD_START + 5, 4'h0, -1, "hold_ignore");
        press(4'h0, 4'b0110, -1, 4'h0, -1, "back2back");
        idle(2, "idle6");

        press(4'h5, 4'b1101, -1, 4'h0, HOLD_START + 10, "abort");
        reset = 1'b0;
        push_exp(4'b1111, 1'b0, 1'b0);
        step("abort_rst");
        reset = 1'b1;
        idle(3, "post_abort");
        press(4'h5, 4'b1101, -1, 4'h0, -1, "after_abort");
        idle(2, "idle7");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
